// File: rtl/cpu_io_port_pkg.sv
// Shared constants for the CPU parallel I/O port endpoint.
package cpu_io_port_pkg;

  // Word width of the CPU in_port/out_port; also used by the CPU top.
  localparam int unsigned CPU_WORD_W = 16;

  // Default out-FIFO depth and drop-counter width.
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned DEF_DROP_W     = 8;

endpackage : cpu_io_port_pkg

// File: rtl/cpu_io_port_fifo.sv
// First-word fall-through synchronous FIFO with separate occupancy count.
module sync_fifo_fwft #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [DATA_W-1:0]         push_data_i,
  input  logic                      pop_i,
  output logic [DATA_W-1:0]         pop_data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A pop frees the slot in the same edge, so a full FIFO can still take a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  // Pointer and count registers; reset discards contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule : sync_fifo_fwft

// File: rtl/cpu_io_port.sv
// Peripheral-side endpoint of the CPU parallel I/O port: out-FIFO to host, in register from host.
module cpu_io_port
  import cpu_io_port_pkg::*;
#(
  parameter int unsigned DATA_W     = CPU_WORD_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned DROP_W     = DEF_DROP_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             cpu_out_data,
  input  logic                          cpu_out_valid,
  output logic [DATA_W-1:0]             cpu_in_data,
  output logic [DATA_W-1:0]             host_tx_data,
  output logic                          host_tx_valid,
  input  logic                          host_tx_ready,
  input  logic [DATA_W-1:0]             host_rx_data,
  input  logic                          host_rx_valid,
  output logic                          host_rx_ready,
  output logic                          in_fresh,
  input  logic                          in_fresh_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [DROP_W-1:0]             drop_cnt,
  input  logic                          ovf_clr
);

  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              accept;
  logic              drop;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DATA_W-1:0] in_reg_q, in_reg_d;
  logic              in_fresh_q, in_fresh_d;

  assign host_tx_valid = !fifo_empty;
  assign pop           = host_tx_valid && host_tx_ready;
  assign accept        = !fifo_full || pop;
  assign drop          = cpu_out_valid && !accept;

  // Out-side word queue toward the host.
  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_out_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (cpu_out_valid && accept),
    .push_data_i (cpu_out_data),
    .pop_i       (pop),
    .pop_data_o  (host_tx_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Overflow/drop bookkeeping; a drop in the clear cycle counts as the first new drop.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr)                drop_cnt_d = DROP_W'(1);
      else if (drop_cnt_q != '1)  drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // In register; a load beats a simultaneous fresh-clear.
  always_comb begin
    in_reg_d   = in_reg_q;
    in_fresh_d = in_fresh_q;
    if (host_rx_valid) begin
      in_reg_d   = host_rx_data;
      in_fresh_d = 1'b1;
    end else if (in_fresh_clr) begin
      in_fresh_d = 1'b0;
    end
  end

  // Status and in-side registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      in_reg_q   <= '0;
      in_fresh_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      in_reg_q   <= in_reg_d;
      in_fresh_q <= in_fresh_d;
    end
  end

  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;
  assign cpu_in_data   = in_reg_q;
  assign in_fresh      = in_fresh_q;
  assign host_rx_ready = 1'b1;

endmodule : cpu_io_port

// File: tb/tb_cpu_io_port.sv
// Directed self-checking bench for cpu_io_port with a host-side scoreboard.
module tb_cpu_io_port;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] cpu_out_data;
  logic          cpu_out_valid;
  logic [DW-1:0] cpu_in_data;
  logic [DW-1:0] host_tx_data;
  logic          host_tx_valid;
  logic          host_tx_ready;
  logic [DW-1:0] host_rx_data;
  logic          host_rx_valid;
  logic          host_rx_ready;
  logic          in_fresh;
  logic          in_fresh_clr;
  logic [3:0]    fifo_count;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic          ovf_clr;

  cpu_io_port #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .DROP_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_out_data  (cpu_out_data),
    .cpu_out_valid (cpu_out_valid),
    .cpu_in_data   (cpu_in_data),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready),
    .host_rx_data  (host_rx_data),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready),
    .in_fresh      (in_fresh),
    .in_fresh_clr  (in_fresh_clr),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt),
    .ovf_clr       (ovf_clr)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference state
  logic [DW-1:0] sb[$];
  int unsigned   m_count;
  logic          m_ovf;
  int unsigned   m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock: optional CPU write, optional host ready, optional overflow clear.
  task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rdy, input logic clr);
    logic do_pop;
    logic acc;
    cpu_out_valid = wv;
    cpu_out_data  = wd;
    host_tx_ready = rdy;
    ovf_clr       = clr;
    do_pop = rdy && (m_count != 0);
    chk("tx_valid_pre", 32'(host_tx_valid), 32'(m_count != 0));
    if (do_pop) begin
      chk("tx_data", 32'(host_tx_data), 32'(sb[0]));
      void'(sb.pop_front());
      m_count--;
    end
    acc = wv && ((m_count < DEPTH) || do_pop);
    if (wv && (m_count < DEPTH)) begin
      sb.push_back(wd);
      m_count++;
    end else if (wv && !acc) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    tick();
    cpu_out_valid = 1'b0;
    host_tx_ready = 1'b0;
    ovf_clr       = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, 32'(fifo_count), m_count);
    chk({tag, "_ovf"},   32'(overflow),   32'(m_ovf));
    chk({tag, "_drop"},  32'(drop_cnt),   m_drop);
  endtask

  initial begin
    rst = 1'b1;
    cpu_out_data = '0; cpu_out_valid = 1'b0; host_tx_ready = 1'b0;
    host_rx_data = '0; host_rx_valid = 1'b0; in_fresh_clr = 1'b0; ovf_clr = 1'b0;
    m_count = 0; m_ovf = 1'b0; m_drop = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset / idle
    chk("rst_valid",  32'(host_tx_valid), 0);
    chk("rst_in",     32'(cpu_in_data),   0);
    chk("rst_fresh",  32'(in_fresh),      0);
    chk("rx_ready",   32'(host_rx_ready), 1);
    chk_status("rst");

    // Two back-to-back words streamed straight through
    cycle(1'b1, 16'h1234, 1'b1, 1'b0);
    chk("b2b_count1", 32'(fifo_count), 1);
    cycle(1'b1, 16'hABCD, 1'b1, 1'b0);
    chk("b2b_count_peak", 32'(fifo_count), 1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk_status("b2b_end");

    // Fill past capacity with host stalled
    for (int i = 0; i < 10; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    chk("fill_count", 32'(fifo_count), 8);
    chk("fill_ovf",   32'(overflow),   1);
    chk("fill_drop",  32'(drop_cnt),   2);

    // Full FIFO: simultaneous push and pop must not drop
    cycle(1'b1, 16'h55AA, 1'b1, 1'b0);
    chk("fullpp_count", 32'(fifo_count), 8);
    chk("fullpp_drop",  32'(drop_cnt),   2);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", 32'(sb.size()), 0);
    chk_status("drain");
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk_status("clr");

    // Saturation of the drop counter
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    chk("sat_drop", 32'(drop_cnt), 32'hFF);
    chk_status("sat");
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b1);
    chk("clr_drop_ovf",  32'(overflow), 1);
    chk("clr_drop_cnt",  32'(drop_cnt), 1);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk_status("sat_drain");

    // In side
    host_rx_data = 16'hBEEF; host_rx_valid = 1'b1;
    tick();
    host_rx_valid = 1'b0;
    chk("in_data",  32'(cpu_in_data), 32'hBEEF);
    chk("in_fresh", 32'(in_fresh),    1);
    in_fresh_clr = 1'b1;
    tick();
    in_fresh_clr = 1'b0;
    chk("in_fresh_clr", 32'(in_fresh),    0);
    chk("in_hold",      32'(cpu_in_data), 32'hBEEF);
    tick(); tick();
    chk("in_hold2",     32'(cpu_in_data), 32'hBEEF);
    host_rx_data = 16'h1357; host_rx_valid = 1'b1; in_fresh_clr = 1'b1;
    tick();
    host_rx_valid = 1'b0; in_fresh_clr = 1'b0;
    chk("in_load_wins", 32'(in_fresh),    1);
    chk("in_data2",     32'(cpu_in_data), 32'h1357);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(16'h0A00 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    chk("pre_rst_ovf", 32'(overflow), 1);
    rst = 1'b1;
    cpu_out_valid = 1'b1; cpu_out_data = 16'h7777;
    host_rx_valid = 1'b0;
    tick();
    rst = 1'b0; cpu_out_valid = 1'b0;
    sb.delete(); m_count = 0; m_ovf = 1'b0; m_drop = 0;
    chk("mrst_valid", 32'(host_tx_valid), 0);
    chk("mrst_in",    32'(cpu_in_data),   0);
    chk("mrst_fresh", 32'(in_fresh),      0);
    chk_status("mrst");

    // Post-reset sanity: single word round trip
    cycle(1'b1, 16'hC0DE, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk_status("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cpu_io_port

// File: doc/cpu_io_port.md
Name: cpu_io_port

Overview:
- Peripheral-side endpoint of the CPU's parallel I/O port.
- Out side: captures each word the CPU emits on its out_port/output_valid pair into a FIFO, then drains it to a host-side valid/ready stream.
- In side: holds the word the CPU samples via its in_port, loaded from a host-side valid/ready stream.
- Sits between the CPU top and the board-level host link (UART/debug bridge).

Parameters:
DATA_W, 16, width of CPU port words
FIFO_DEPTH, 8, out-FIFO entries; power of two, >= 2
DROP_W, 8, width of saturating drop counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
cpu_out_data  input  DATA_W  CPU out_port value
cpu_out_valid  input  1  CPU output_valid; each high cycle is one word
cpu_in_data  output  DATA_W  drives CPU in_port
host_tx_data  output  DATA_W  head of out-FIFO
host_tx_valid  output  1  out-FIFO non-empty
host_tx_ready  input  1  host accepts head word
host_rx_data  input  DATA_W  word for CPU in_port
host_rx_valid  input  1  host offers word
host_rx_ready  output  1  constant 1; in register always accepts
in_fresh  output  1  in register loaded since last clear
in_fresh_clr  input  1  clears in_fresh
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  output  1  sticky: at least one CPU word dropped
drop_cnt  output  DROP_W  saturating count of dropped words
ovf_clr  input  1  clears overflow and drop_cnt

Behaviour:
- Reset: synchronous; when rst is high at a posedge, these are forced to 0: FIFO pointers, count, in register, in_fresh, overflow, drop_cnt. Consequently host_tx_valid=0 and cpu_in_data=0. Reset mid-transfer discards FIFO contents; there is no partial state.
- Push: on a posedge with cpu_out_valid=1, write cpu_out_data if accept = !full || pop.
- Pop: occurs when host_tx_valid && host_tx_ready.
- FIFO mode: first-word fall-through. host_tx_data = mem[rd_ptr]; host_tx_valid = (count != 0).
- Latency: a word pushed at edge N appears on host_tx_valid/host_tx_data after edge N (zero-cycle bubble). Back-to-back CPU writes are accepted every cycle until full.
- Simultaneous push+pop:
  - count unchanged.
  - When full, both proceed and no word is dropped.
  - When empty, pop cannot occur because valid is low; push proceeds.
- Pointers: log2(DEPTH)-bit read and write pointers, wrapping naturally; separate count register.
- Overflow: cpu_out_valid=1 and !accept means the word is discarded. overflow<=1, and drop_cnt increments, saturating at all-ones.
- Clear: ovf_clr clears overflow and drop_cnt. If ovf_clr coincides with a drop, the drop wins: overflow=1, drop_cnt=1.
- FIFO data is never altered by overflow.
- In side: on host_rx_valid, in_reg<=host_rx_data and in_fresh<=1. cpu_in_data = in_reg, registered, visible the cycle after the load edge. in_reg holds indefinitely otherwise.
- in_fresh_clr clears in_fresh. A load coinciding with in_fresh_clr wins: in_fresh=1.
- host_rx_ready is tied to 1.
- Out side and in side are independent; no cross-coupling.
- No combinational path from cpu_out_* to host_tx_*, except that accept depends on host_tx_ready via pop.

Decomposition:
- Shared package constant: CPU_WORD_W = 16, which the CPU top also uses.
- Natural sub-module: sync_fifo_fwft (DATA_W, DEPTH params; push/pop/full/empty/count). It is reusable for a future host-to-CPU input queue.
- Overflow/drop logic and the in register stay in cpu_io_port.

Test Plan:
- Reset then idle → host_tx_valid=0, cpu_in_data=0x0000, fifo_count=0, overflow=0, drop_cnt=0.
- CPU writes 0x1234, 0xABCD on consecutive cycles, host_tx_ready=1 → host receives 0x1234 then 0xABCD in order; fifo_count peaks at 1.
- host_tx_ready=0, 10 consecutive CPU writes 0..9 (DEPTH=8) → fifo_count=8, overflow=1, drop_cnt=2. Drain yields 0..7 only.
- FIFO full, same cycle CPU write 0x55AA and host pop → no drop; count stays 8; 0x55AA is the last word drained.
- 300 drops with host stalled → drop_cnt saturates at 0xFF. Then ovf_clr coinciding with one more drop → overflow=1, drop_cnt=1.
- host_rx_valid with 0xBEEF → cpu_in_data=0xBEEF and in_fresh=1 the next cycle. in_fresh_clr → in_fresh=0, value held. Assert rst mid-stream → all outputs 0 the next cycle.
